// File: rtl/regbank_wr_arb.sv
// Round-robin write arbiter owning a shared register bank.
// One granted requester commits per cycle; the bank is read combinationally.
module regbank_wr_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    dat_i,
  output logic [NUM_REQ-1:0]               gnt_o,
  input  logic                             freeze_i,
  input  logic [ADDR_WIDTH-1:0]            raddr_i,
  output logic [DATA_WIDTH-1:0]            rdat_o,
  output logic                             wr_vld_o,
  output logic [$clog2(NUM_REQ)-1:0]       wr_idx_o,
  output logic [ADDR_WIDTH-1:0]            wr_addr_o
);

  localparam int unsigned IdxWidth  = $clog2(NUM_REQ);
  localparam int unsigned CandWidth = IdxWidth + 1;

  logic [IdxWidth-1:0]   ptr_q, ptr_d;
  logic                  wr_vld_q;
  logic [IdxWidth-1:0]   wr_idx_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] bank_q [DEPTH];

  logic                  gnt_vld;
  logic [IdxWidth-1:0]   gnt_idx;
  logic [CandWidth-1:0]  cand;
  logic [IdxWidth-1:0]   cand_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_dat;

  // Scan requesters starting at ptr_q, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    gnt_o    = '0;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    cand_idx = '0;
    if (rst_n_i && !freeze_i) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, ptr_q} + CandWidth'(k);
        if (cand >= CandWidth'(NUM_REQ)) begin
          cand = cand - CandWidth'(NUM_REQ);
        end
        cand_idx = cand[IdxWidth-1:0];
        if (!gnt_vld && req_i[cand_idx]) begin
          gnt_vld         = 1'b1;
          gnt_idx         = cand_idx;
          gnt_o[cand_idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_addr = addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    sel_dat  = dat_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    // Explicit wrap keeps non-power-of-two NUM_REQ in range.
    if (gnt_idx == IdxWidth'(NUM_REQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q     <= '0;
      wr_vld_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_addr_q <= '0;
    end else begin
      wr_vld_q <= gnt_vld;
      if (gnt_vld) begin
        ptr_q     <= ptr_d;
        wr_idx_q  <= gnt_idx;
        wr_addr_q <= sel_addr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        bank_q[e] <= '0;
      end
    end else if (gnt_vld) begin
      bank_q[sel_addr] <= sel_dat;
    end
  end

  assign rdat_o    = bank_q[raddr_i];
  assign wr_vld_o  = wr_vld_q;
  assign wr_idx_o  = wr_idx_q;
  assign wr_addr_o = wr_addr_q;

endmodule

// File: tb/tb_regbank_wr_arb.sv
// Scoreboarded bench for regbank_wr_arb: expected commits are queued at grant time
// and retired against wr_idx_o/wr_addr_o; a shadow bank checks rdat_o.
`timescale 1ns/1ps
module tb_regbank_wr_arb;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int DP = 8;
  localparam int AW = 3;

  typedef struct packed {
    logic [1:0]    idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [NR*AW-1:0] addr_v;
  logic [NR*DW-1:0] dat_v;
  logic [NR-1:0]   gnt;
  logic            freeze;
  logic [AW-1:0]   raddr;
  logic [DW-1:0]   rdat;
  logic            wr_vld;
  logic [1:0]      wr_idx;
  logic [AW-1:0]   wr_addr;

  int checks = 0;
  int failures = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [DW-1:0] exp_bank [DP];

  regbank_wr_arb #(
    .NUM_REQ(NR),
    .DATA_WIDTH(DW),
    .DEPTH(DP)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .req_i(req),
    .addr_i(addr_v),
    .dat_i(dat_v),
    .gnt_o(gnt),
    .freeze_i(freeze),
    .raddr_i(raddr),
    .rdat_o(rdat),
    .wr_vld_o(wr_vld),
    .wr_idx_o(wr_idx),
    .wr_addr_o(wr_addr)
  );

  always #50 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Retire one expected commit per observed write; shadow bank follows commits.
  always @(posedge clk) begin
    #1;
    if (rst_n && wr_vld) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_write got idx=%0d addr=%0d, expected no write", wr_idx, wr_addr);
      end else begin
        mon_e = sb_q.pop_front();
        if (wr_idx !== mon_e.idx || wr_addr !== mon_e.addr) begin
          failures++;
          $display("FAIL sb_commit got idx=%0d addr=%0d, expected idx=%0d addr=%0d",
                   wr_idx, wr_addr, mon_e.idx, mon_e.addr);
        end
        exp_bank[mon_e.addr] = mon_e.data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_port(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr_v[i*AW +: AW] = a;
    dat_v[i*DW +: DW]  = d;
  endtask

  task automatic push(input int i);
    sb_q.push_back(exp_t'{idx: 2'(i), addr: addr_v[i*AW +: AW], data: dat_v[i*DW +: DW]});
  endtask

  task automatic clear_model();
    for (int e = 0; e < DP; e++) exp_bank[e] = '0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    clear_model();
    rst_n = 1'b0;
    req = 4'b1111;
    freeze = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (gnt !== 4'b0000) begin
        failures++;
        $display("FAIL reset_gnt got %b, expected 0000", gnt);
      end
      checks++;
      if (wr_vld !== 1'b0) begin
        failures++;
        $display("FAIL reset_wr_vld got %b, expected 0", wr_vld);
      end
    end
    for (int a = 0; a < DP; a++) begin
      raddr = 3'(a);
      #1;
      checks++;
      if (rdat !== 32'h0) begin
        failures++;
        $display("FAIL reset_rdat[%0d] got %h, expected 0", a, rdat);
      end
    end
    req = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0100;
    set_port(2, 3'd3, 32'hA5A5_0001);
    #1;
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL single_gnt got %b, expected 0100", gnt);
    end
    push(2);
    tick();
    req = '0;
    raddr = 3'd3;
    #1;
    checks++;
    if (wr_vld !== 1'b1 || wr_idx !== 2'd2 || wr_addr !== 3'd3) begin
      failures++;
      $display("FAIL single_status got vld=%b idx=%0d addr=%0d, expected vld=1 idx=2 addr=3",
               wr_vld, wr_idx, wr_addr);
    end
    checks++;
    if (rdat !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL single_rdat got %h, expected a5a50001", rdat);
    end
  endtask

  // ptr is 3 after the single write to requester 2.
  task automatic test_wrap();
    req = 4'b1001;
    set_port(3, 3'd6, 32'h3333_0006);
    set_port(0, 3'd7, 32'h0000_0007);
    #1;
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_first_gnt got %b, expected 1000", gnt);
    end
    push(3);
    tick();
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_second_gnt got %b, expected 0001", gnt);
    end
    push(0);
    tick();
    req = '0;
    for (int a = 6; a < 8; a++) begin
      raddr = 3'(a);
      #1;
      checks++;
      if (rdat !== exp_bank[a]) begin
        failures++;
        $display("FAIL wrap_rdat[%0d] got %h, expected %h", a, rdat, exp_bank[a]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    rst_n = 1'b0;
    #1;
    clear_model();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) set_port(i, 3'(i), 32'(i));
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      eg = 4'(1 << (k % NR));
      checks++;
      if (gnt !== eg) begin
        failures++;
        $display("FAIL rr_gnt[%0d] got %b, expected %b", k, gnt, eg);
      end
      push(k % NR);
      tick();
    end
    req = '0;
    for (int a = 0; a < NR; a++) begin
      raddr = 3'(a);
      #1;
      checks++;
      if (rdat !== 32'(a)) begin
        failures++;
        $display("FAIL rr_rdat[%0d] got %h, expected %h", a, rdat, 32'(a));
      end
    end
  endtask

  // ptr is 0 after eight round-robin grants.
  task automatic test_freeze();
    set_port(0, 3'd1, 32'hF0F0_0000);
    set_port(1, 3'd2, 32'hF0F0_0001);
    freeze = 1'b1;
    req = 4'b0011;
    repeat (4) begin
      #1;
      checks++;
      if (gnt !== 4'b0000) begin
        failures++;
        $display("FAIL freeze_gnt got %b, expected 0000", gnt);
      end
      tick();
      checks++;
      if (wr_vld !== 1'b0) begin
        failures++;
        $display("FAIL freeze_wr_vld got %b, expected 0", wr_vld);
      end
    end
    for (int a = 1; a < 3; a++) begin
      raddr = 3'(a);
      #1;
      checks++;
      if (rdat !== 32'(a)) begin
        failures++;
        $display("FAIL freeze_bank[%0d] got %h, expected %h", a, rdat, 32'(a));
      end
    end
    freeze = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL unfreeze_gnt got %b, expected 0001", gnt);
    end
    push(0);
    tick();
    req = 4'b0010;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL unfreeze_next_gnt got %b, expected 0010", gnt);
    end
    push(1);
    tick();
    req = '0;
    raddr = 3'd2;
    #1;
    checks++;
    if (rdat !== 32'hF0F0_0001) begin
      failures++;
      $display("FAIL unfreeze_rdat got %h, expected f0f00001", rdat);
    end
  endtask

  // ptr is 2 here; requester 2 wins first, requester 1's value lands last.
  task automatic test_same_addr();
    set_port(1, 3'd5, 32'h0000_1111);
    set_port(2, 3'd5, 32'h0000_2222);
    req = 4'b0110;
    raddr = 3'd5;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL same_addr_gnt1 got %b, expected 0100", gnt);
    end
    checks++;
    if (rdat !== 32'h0) begin
      failures++;
      $display("FAIL same_addr_old1 got %h, expected 0", rdat);
    end
    push(2);
    tick();
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL same_addr_gnt2 got %b, expected 0010", gnt);
    end
    checks++;
    if (rdat !== 32'h0000_2222) begin
      failures++;
      $display("FAIL same_addr_old2 got %h, expected 00002222", rdat);
    end
    push(1);
    tick();
    req = '0;
    #1;
    checks++;
    if (rdat !== 32'h0000_1111) begin
      failures++;
      $display("FAIL same_addr_last got %h, expected 00001111", rdat);
    end
  endtask

  // ptr is 2 here, so the stream runs 2,3,0 before the reset pulse.
  task automatic test_async_reset();
    logic [3:0] eg;
    for (int i = 0; i < NR; i++) set_port(i, 3'(i + 4), 32'hC000_0000 | 32'(i));
    req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      eg = 4'(1 << ((k + 2) % NR));
      checks++;
      if (gnt !== eg) begin
        failures++;
        $display("FAIL stream_gnt[%0d] got %b, expected %b", k, gnt, eg);
      end
      push((k + 2) % NR);
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL areset_gnt got %b, expected 0000", gnt);
    end
    for (int a = 0; a < DP; a++) begin
      raddr = 3'(a);
      #1;
      checks++;
      if (rdat !== 32'h0) begin
        failures++;
        $display("FAIL areset_rdat[%0d] got %h, expected 0", a, rdat);
      end
    end
    clear_model();
    rst_n = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL areset_first_gnt got %b, expected 0001", gnt);
    end
    push(0);
    tick();
    req = '0;
    checks++;
    if (wr_vld !== 1'b1 || wr_idx !== 2'd0) begin
      failures++;
      $display("FAIL areset_first_commit got vld=%b idx=%0d, expected vld=1 idx=0", wr_vld, wr_idx);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    addr_v = '0;
    dat_v  = '0;
    freeze = 1'b0;
    raddr  = '0;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_freeze();
    test_same_addr();
    test_async_reset();
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got %0d pending, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regbank_wr_arb.md
# regbank_wr_arb

Round-robin write arbiter in front of a shared register bank. Up to NUM_REQ masters compete for the bank's single write port. Each cycle the block grants one of them, commits its data into the addressed entry, and advances a fairness pointer. A combinational read port exposes the bank to consumers. The block sits between configuration masters (bus slave, DMA, debug) and the load-enable/reset register bank it owns.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 32, width of each bank entry
- DEPTH, 8, number of bank entries (power of two, ≥2)
- ADDR_WIDTH, $clog2(DEPTH), derived; not to be overridden

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- req_i  in  NUM_REQ  per-requester write request
- addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester write address; requester i uses slice i
- dat_i  in  NUM_REQ*DATA_WIDTH  per-requester write data; requester i uses slice i
- gnt_o  out  NUM_REQ  one-hot grant, combinational from req_i, freeze_i and the pointer
- freeze_i  in  1  suppresses all grants while high
- raddr_i  in  ADDR_WIDTH  read address
- rdat_o  out  DATA_WIDTH  bank[raddr_i], combinational
- wr_vld_o  out  1  registered: a write was committed at the last edge
- wr_idx_o  out  $clog2(NUM_REQ)  registered: index of the last committed requester
- wr_addr_o  out  ADDR_WIDTH  registered: address of the last committed write

## Operation
- Bank:
  - DEPTH entries of DATA_WIDTH.
  - Async reset to all zeros.
  - Written only on a granted request.
- Round-robin pointer `ptr`, range 0..NUM_REQ-1, reset to 0.
- Priority order for a cycle is ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1, with wrap modulo NUM_REQ.
- Grant:
  - gnt_o[i]=1 for the first i in priority order with req_i[i]=1, provided freeze_i=0.
  - Otherwise gnt_o is all zeros.
  - gnt_o is never more than one-hot.
- Commit at a clock edge where gnt_o[i]=1:
  - bank[addr_i slice i] ← dat_i slice i
  - ptr ← (i+1) mod NUM_REQ
  - wr_vld_o ← 1, wr_idx_o ← i, wr_addr_o ← addr_i slice i
- At an edge with no grant:
  - ptr holds and the bank holds.
  - wr_vld_o ← 0; wr_idx_o and wr_addr_o hold.
- Requester handshake:
  - A requester holds req_i, addr and data stable until it samples gnt_o=1 at a clock edge.
  - The transfer completes at that edge.
  - The requester may keep req_i high for back-to-back writes. Each granted cycle is one write.
- Fairness: with all requests continuously high, grants rotate 0,1,…,NUM_REQ-1,0,… A waiting requester is granted within NUM_REQ cycles unless freeze_i is asserted.
- freeze_i:
  - Takes effect in the same cycle.
  - Requests stay pending. ptr, bank and wr_idx_o/wr_addr_o are unchanged; wr_vld_o ← 0.
- Out-of-range addresses cannot occur because DEPTH is a power of two. Every address is valid.

## Timing
- Reset values: bank all 0, ptr=0, wr_vld_o=0, wr_idx_o=0, wr_addr_o=0.
- While reset is asserted gnt_o is all zeros. rdat_o reads 0.
- Grant latency: 0 cycles. gnt_o is valid in the same cycle req_i rises.
- Write latency: data is visible on rdat_o in the cycle after the granting edge.
- Read-during-write to the same address returns the old value in the grant cycle and the new value afterwards.
- Throughput: one write per cycle, sustained.
- Simultaneous requests to the same address from different requesters: only the granted one writes that cycle. The other writes in a later grant cycle, so the last granted value wins.
- Reset mid-operation:
  - Asserting rst_n_i asynchronously clears the bank and all state.
  - A write at the same edge is lost.
  - Operation resumes with ptr=0 on the first edge after deassertion.
- Combinational path: req_i/freeze_i → gnt_o. Requesters must not make req_i depend combinationally on gnt_o.

## Test plan
- Reset: hold rst_n_i=0 for 3 cycles → rdat_o=0 for every raddr_i; gnt_o=0; wr_vld_o=0.
- Single requester: req_i=4'b0100, addr 3, data 0xA5A5_0001 for 1 cycle → gnt_o=4'b0100. Next cycle rdat_o(raddr 3)=0xA5A5_0001, wr_vld_o=1, wr_idx_o=2, wr_addr_o=3. ptr becomes 3.
- Round-robin: req_i=4'b1111 held 8 cycles, each requester writing its own address i with data i → grant sequence 0,1,2,3,0,1,2,3; entries 0..3 hold 0..3.
- Wrap priority: set ptr=3 via a grant to requester 2, then req_i=4'b1001 → requester 3 granted first, then requester 0.
- Freeze: req_i=4'b0011 with freeze_i=1 for 4 cycles → gnt_o=0, bank unchanged, wr_vld_o=0. After releasing freeze_i, requester at ptr is granted in the same cycle.
- Async reset mid-burst: req_i=4'b1111 streaming, rst_n_i pulsed low between edges → all entries read 0 immediately. After release, the first grant goes to requester 0.
